// File: rtl/cnn_pkg.sv
// Shared types and sizing for the CNN frame scheduler.
// Holds the sequencer state encoding and chain-wide widths.
package cnn_pkg;

  localparam int CNN_NUM_LAYERS = 5;
  localparam int CNN_RES_W      = 8;
  localparam int CNN_IDX_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    STRT,
    RUN,
    TX,
    WAIT_TX,
    CLR
  } seq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer run timer: counts while enabled, expire flags the last allowed cycle.
// Zero latency on expire; clear wins over enable.
module seq_watchdog #(
  parameter int TO_CYC = 4096,
  parameter int TO_W   = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == TO_W'(TO_CYC - 1));

endmodule

// File: rtl/cnn_layer_seq.sv
// Frame scheduler: starts each CNN layer in turn, ships the result byte to the UART,
// then pulses the chain-wide clear. A stalled layer is dropped by the watchdog.
module cnn_layer_seq
  import cnn_pkg::*;
#(
  parameter int NUM_LAYERS = CNN_NUM_LAYERS,
  parameter int TO_CYC     = 4096,
  parameter int TO_W       = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  img_rdy,
  input  logic [NUM_LAYERS-1:0] lyr_done,
  input  logic                  res_vld,
  input  logic [CNN_RES_W-1:0]  res_byte,
  input  logic                  tx_busy,
  input  logic                  uart_tx_done,
  output logic [NUM_LAYERS-1:0] lyr_strt,
  output logic                  tx_start,
  output logic [CNN_RES_W-1:0]  tx_data,
  output logic                  clr,
  output logic                  busy,
  output logic                  err,
  output logic [CNN_IDX_W-1:0]  err_layer,
  input  logic                  err_clr,
  output logic [15:0]           frame_cnt,
  output logic [7:0]            drop_cnt
);

  localparam logic [CNN_IDX_W-1:0] LAST_IDX = CNN_IDX_W'(NUM_LAYERS - 1);

  seq_state_t             state_q, state_d;
  logic [CNN_IDX_W-1:0]   idx_q, idx_d;
  logic [CNN_RES_W-1:0]   tx_data_q, tx_data_d;
  logic                   err_q, err_d;
  logic [CNN_IDX_W-1:0]   err_layer_q, err_layer_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;

  logic wd_clear;
  logic wd_en;
  logic wd_expire;

  assign wd_clear = (state_q == STRT);
  assign wd_en    = (state_q == RUN);

  seq_watchdog #(
    .TO_CYC (TO_CYC),
    .TO_W   (TO_W)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    err_d       = err_q;
    err_layer_d = err_layer_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    lyr_strt    = '0;
    tx_start    = 1'b0;
    clr         = 1'b0;

    if (err_clr) begin
      err_d       = 1'b0;
      err_layer_d = '0;
    end

    if (img_rdy && (state_q != IDLE)) begin
      drop_cnt_d = sat_inc8(drop_cnt_q);
    end

    case (state_q)
      IDLE: begin
        if (img_rdy) begin
          idx_d   = '0;
          state_d = STRT;
        end
      end
      STRT: begin
        lyr_strt = NUM_LAYERS'(1) << idx_q;
        state_d  = RUN;
      end
      RUN: begin
        // A completion seen on the expiry cycle still counts; the timeout path
        // also overrides a simultaneous err_clr.
        if (idx_q != LAST_IDX) begin
          if (lyr_done[idx_q]) begin
            idx_d   = idx_q + 1'b1;
            state_d = STRT;
          end else if (wd_expire) begin
            err_d       = 1'b1;
            err_layer_d = idx_q;
            state_d     = CLR;
          end
        end else begin
          if (res_vld) begin
            tx_data_d = res_byte;
            state_d   = TX;
          end else if (wd_expire) begin
            err_d       = 1'b1;
            err_layer_d = idx_q;
            state_d     = CLR;
          end
        end
      end
      TX: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (uart_tx_done) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = CLR;
        end
      end
      CLR: begin
        clr     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tx_data_q   <= '0;
      err_q       <= 1'b0;
      err_layer_q <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      err_q       <= err_d;
      err_layer_q <= err_layer_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign err_layer = err_layer_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  a_strt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(lyr_strt));
  a_start_idle:  assert property (@(posedge clk) disable iff (!rst_n) tx_start |-> !tx_busy);

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed bench for cnn_layer_seq: frame table plus hang, race and reset sequences.
module tb_cnn_layer_seq;

  localparam int NL = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          img_rdy;
  logic [NL-1:0] lyr_done;
  logic          res_vld;
  logic [7:0]    res_byte;
  logic          tx_busy;
  logic          uart_tx_done;
  logic [NL-1:0] lyr_strt;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          clr;
  logic          busy;
  logic          err;
  logic [2:0]    err_layer;
  logic          err_clr;
  logic [15:0]   frame_cnt;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad = 0;
  int mon_clr_n = 0;
  int mon_txs_n = 0;

  typedef struct {
    logic [7:0]  rb;
    int          dly;
    int          busy_cyc;
    int          ovr;
    int          clr_ovr;
    logic [15:0] exp_fc;
    logic [7:0]  exp_drop;
  } frame_vec_t;

  frame_vec_t vecs[5];

  always #5 clk = ~clk;

  cnn_layer_seq #(
    .NUM_LAYERS (NL),
    .TO_CYC     (16),
    .TO_W       (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .img_rdy      (img_rdy),
    .lyr_done     (lyr_done),
    .res_vld      (res_vld),
    .res_byte     (res_byte),
    .tx_busy      (tx_busy),
    .uart_tx_done (uart_tx_done),
    .lyr_strt     (lyr_strt),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .clr          (clr),
    .busy         (busy),
    .err          (err),
    .err_layer    (err_layer),
    .err_clr      (err_clr),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt)
  );

  always @(negedge clk) begin
    if (clr) mon_clr_n++;
    if (tx_start) mon_txs_n++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strt(input int k, output int w);
    w = 0;
    while (lyr_strt == '0 && w < 64) begin
      step();
      w++;
    end
    chk($sformatf("strt%0d", k), 32'(lyr_strt), 32'(1 << k));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_outs"}, 32'({lyr_strt, tx_start, tx_data, clr, busy, err, err_layer}), 32'd0);
    chk({nm, "_cnts"}, {frame_cnt, 8'd0, drop_cnt}, 32'd0);
  endtask

  task automatic quick_layer(input int k);
    int w;
    wait_strt(k, w);
    step();
    lyr_done[k] = 1'b1;
    step();
    lyr_done = '0;
  endtask

  task automatic run_frame(input frame_vec_t v);
    int w;
    int clr0;
    int txs0;
    int bad_hold;
    clr0 = mon_clr_n;
    txs0 = mon_txs_n;
    img_rdy = 1'b1;
    step();
    img_rdy = 1'b0;
    for (int k = 0; k < NL; k++) begin
      wait_strt(k, w);
      chk("strt_lat", 32'(w), 32'd0);
      for (int i = 0; i < v.dly; i++) step();
      if (k < NL - 1) begin
        lyr_done[k] = 1'b1;
        step();
        lyr_done = '0;
      end
    end
    tx_busy  = (v.busy_cyc > 0);
    res_vld  = 1'b1;
    res_byte = v.rb;
    step();
    res_vld  = 1'b0;
    res_byte = 8'hEE;
    bad_hold = 0;
    for (int i = 0; i < v.busy_cyc; i++) begin
      img_rdy = (i < v.ovr);
      @(negedge clk);
      if (tx_start !== 1'b0 || tx_data !== v.rb) bad_hold++;
      step();
    end
    img_rdy = 1'b0;
    tx_busy = 1'b0;
    chk("hold_busy", 32'(bad_hold), 32'd0);
    @(negedge clk);
    chk("tx_start", 32'(tx_start), 32'd1);
    chk("tx_data", 32'(tx_data), 32'(v.rb));
    step();
    repeat (3) step();
    chk("clr_early", 32'(clr), 32'd0);
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    chk("clr", 32'(clr), 32'd1);
    chk("tx_data_clr", 32'(tx_data), 32'(v.rb));
    chk("frame_cnt", 32'(frame_cnt), 32'(v.exp_fc));
    img_rdy = (v.clr_ovr != 0);
    step();
    img_rdy = 1'b0;
    chk("idle_after", 32'(busy), 32'd0);
    step();
    chk("stay_idle", 32'(busy), 32'd0);
    chk("drop_cnt", 32'(drop_cnt), 32'(v.exp_drop));
    chk("clr_pulses", 32'(mon_clr_n - clr0), 32'd1);
    chk("tx_starts", 32'(mon_txs_n - txs0), 32'd1);
  endtask

  initial begin
    int w;
    frame_vec_t fv;

    vecs[0] = '{8'h07, 10, 0,   0,   0, 16'd1, 8'd0};
    vecs[1] = '{8'h03, 1,  0,   0,   0, 16'd2, 8'd0};
    vecs[2] = '{8'h09, 4,  20,  3,   0, 16'd3, 8'd3};
    vecs[3] = '{8'h05, 2,  2,   0,   1, 16'd4, 8'd4};
    vecs[4] = '{8'h00, 2,  300, 260, 0, 16'd5, 8'hFF};

    rst_n = 1'b0;
    img_rdy = 1'b0;
    lyr_done = '0;
    res_vld = 1'b0;
    res_byte = 8'h00;
    tx_busy = 1'b0;
    uart_tx_done = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    for (int n = 0; n < 5; n++) run_frame(vecs[n]);

    // layer 2 hangs until the watchdog fires
    img_rdy = 1'b1;
    step();
    img_rdy = 1'b0;
    quick_layer(0);
    quick_layer(1);
    wait_strt(2, w);
    repeat (16) step();
    chk("hang_no_err_yet", 32'({err, clr}), 32'd0);
    step();
    chk("hang_clr", 32'(clr), 32'd1);
    chk("hang_err", 32'(err), 32'd1);
    chk("hang_err_layer", 32'(err_layer), 32'd2);
    step();
    chk("hang_idle", 32'({busy, clr}), 32'd0);
    chk("hang_frame_cnt", 32'(frame_cnt), 32'd5);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", 32'({err, err_layer}), 32'd0);
    fv = '{8'h06, 3, 0, 0, 0, 16'd6, 8'hFF};
    run_frame(fv);

    // completion on the expiry cycle, wrong-index done, err_clr racing a timeout
    img_rdy = 1'b1;
    step();
    img_rdy = 1'b0;
    wait_strt(0, w);
    repeat (16) step();
    lyr_done[0] = 1'b1;
    step();
    lyr_done = '0;
    chk("race_done_strt", 32'(lyr_strt), 32'd2);
    chk("race_done_err", 32'(err), 32'd0);
    repeat (3) step();
    lyr_done = 5'b11101;
    step();
    lyr_done = '0;
    chk("wrong_idx_strt", 32'(lyr_strt), 32'd0);
    chk("wrong_idx_busy", 32'(busy), 32'd1);
    repeat (2) step();
    lyr_done[1] = 1'b1;
    step();
    lyr_done = '0;
    chk("right_idx_strt", 32'(lyr_strt), 32'd4);
    repeat (16) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("race_errclr_err", 32'(err), 32'd1);
    chk("race_errclr_layer", 32'(err_layer), 32'd2);
    chk("race_errclr_clr", 32'(clr), 32'd1);
    step();
    chk("race_frame_cnt", 32'(frame_cnt), 32'd6);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // reset while layer 3 is running
    img_rdy = 1'b1;
    step();
    img_rdy = 1'b0;
    quick_layer(0);
    quick_layer(1);
    quick_layer(2);
    wait_strt(3, w);
    repeat (2) step();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    w = mon_clr_n;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset_no_clr", 32'(mon_clr_n - w), 32'd0);
    fv = '{8'h04, 2, 0, 0, 0, 16'd1, 8'd0};
    run_frame(fv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
